// File: rtl/alu_pkg.sv
//==============================================================================
// Module      : alu_pkg
// Description : Shared constants for the ALU datapath: default data width and
//               the 3-bit ALU operation encodings.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
//==============================================================================
// Module      : alu_core
// Description : Purely combinational ALU. Computes result and signed-overflow
//               flag for the selected operation.
//               Ports: a, b (operands), op (3-bit select) -> result, ovf.
//               Macro ALU_SHIFT_EN builds the shifter; without it SRL/SLL
//               return 0.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int c_msb = WIDTH - 1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_slt;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sll;

    assign w_sum  = a + b;
    assign w_diff = a - b;

    // Overflow: like-signed operands for ADD (unlike-signed for SUB) whose
    // result sign differs from a.
    assign w_add_ovf = (a[c_msb] == b[c_msb]) && (w_sum[c_msb]  != a[c_msb]);
    assign w_sub_ovf = (a[c_msb] != b[c_msb]) && (w_diff[c_msb] != a[c_msb]);

    // When signs differ the negative operand is the smaller one; only for
    // like signs is the difference sign trustworthy (no overflow possible).
    assign w_slt = (a[c_msb] != b[c_msb]) ? a[c_msb] : w_diff[c_msb];

`ifdef ALU_SHIFT_EN
    assign w_srl = a >> b[4:0];
    assign w_sll = a << b[4:0];
`else
    assign w_srl = '0;
    assign w_sll = '0;
`endif

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR : result = a | b;
            OP_ADD: begin
                result = w_sum;
                ovf    = w_add_ovf;
            end
            OP_XOR: result = a ^ b;
            OP_SRL: result = w_srl;
            OP_SLL: result = w_sll;
            OP_SUB: begin
                result = w_diff;
                ovf    = w_sub_ovf;
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, w_slt};
            default: result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_datapath.sv
//==============================================================================
// Module      : alu_datapath
// Description : Execute-stage datapath: registered ALU result/flags, fetch
//               PC+4 and branch target. All results have one cycle latency;
//               hold stalls every output register, reset overrides hold.
//               Ports: clk, reset (sync, active-high), hold, alu_a, alu_b,
//               alu_op, pc_f, pc_plus4_d, imm_ext -> alu_out, zero, ovf,
//               pc_plus4_f, branch_target.
//               Macro ALU_SHIFT_EN enables SRL/SLL in the ALU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] pc_f,
    input  logic [WIDTH-1:0] pc_plus4_d,
    input  logic [WIDTH-1:0] imm_ext,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] pc_plus4_f,
    output logic [WIDTH-1:0] branch_target
);

    localparam logic [WIDTH-1:0] c_four = WIDTH'(4);

    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch;

    logic [WIDTH-1:0] r_alu_out;
    logic             r_zero;
    logic             r_ovf;
    logic [WIDTH-1:0] r_pc_plus4_f;
    logic [WIDTH-1:0] r_branch_target;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (w_result),
        .ovf    (w_ovf)
    );

    assign w_pc_plus4 = pc_f + c_four;
    // Immediate is a word offset; two's-complement wrap handles negatives.
    assign w_branch   = pc_plus4_d + (imm_ext << 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_out       <= '0;
            r_zero          <= 1'b1;  // matches the cleared alu_out
            r_ovf           <= 1'b0;
            r_pc_plus4_f    <= '0;
            r_branch_target <= '0;
        end else if (!hold) begin
            r_alu_out       <= w_result;
            r_zero          <= (w_result == '0);
            r_ovf           <= w_ovf;
            r_pc_plus4_f    <= w_pc_plus4;
            r_branch_target <= w_branch;
        end
    end

    assign alu_out       = r_alu_out;
    assign zero          = r_zero;
    assign ovf           = r_ovf;
    assign pc_plus4_f    = r_pc_plus4_f;
    assign branch_target = r_branch_target;

endmodule

`default_nettype wire

// File: tb/tb_alu_datapath.sv
//==============================================================================
// Module      : tb_alu_datapath
// Description : Self-checking scoreboard bench for alu_datapath (WIDTH=32).
//               Honours ALU_SHIFT_EN the same way as the design.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_datapath;

    logic        clk;
    logic        reset;
    logic        hold;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_d;
    logic [31:0] imm_ext;
    logic [31:0] alu_out;
    logic        zero;
    logic        ovf;
    logic [31:0] pc_plus4_f;
    logic [31:0] branch_target;

    typedef struct {
        logic [31:0] alu_out;
        logic        zero;
        logic        ovf;
        logic [31:0] pc4;
        logic [31:0] bt;
    } exp_t;

    exp_t q_exp[$];
    exp_t r_last;
    int   n_checks;
    int   n_pass;

    alu_datapath #(
        .WIDTH (32)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .hold          (hold),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .pc_f          (pc_f),
        .pc_plus4_d    (pc_plus4_d),
        .imm_ext       (imm_ext),
        .alu_out       (alu_out),
        .zero          (zero),
        .ovf           (ovf),
        .pc_plus4_f    (pc_plus4_f),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference ALU built on wide signed arithmetic.
    function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic v);
        longint s;
        v = 1'b0;
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: begin
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                return s[31:0];
            end
            3'd3: return a ^ b;
`ifdef ALU_SHIFT_EN
            3'd4: return a >> b[4:0];
            3'd5: return a << b[4:0];
`else
            3'd4: return 32'd0;
            3'd5: return 32'd0;
`endif
            3'd6: begin
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                return s[31:0];
            end
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Drive one cycle of stimulus, push its expectation, clock it, compare.
    task automatic step(input logic rst, input logic hld, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic [31:0] p4d, input logic [31:0] imm);
        exp_t e;
        exp_t g;
        logic v;
        reset = rst; hold = hld; alu_op = op; alu_a = a; alu_b = b;
        pc_f = pc; pc_plus4_d = p4d; imm_ext = imm;
        if (rst) begin
            e.alu_out = 0; e.zero = 1; e.ovf = 0; e.pc4 = 0; e.bt = 0;
        end else if (hld) begin
            e = r_last;
        end else begin
            e.alu_out = m_alu(op, a, b, v);
            e.ovf     = v;
            e.zero    = (e.alu_out == 0);
            e.pc4     = pc + 32'd4;
            e.bt      = p4d + imm * 32'd4;
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            g = q_exp.pop_front();
            chk("alu_out",       alu_out,              g.alu_out);
            chk("zero",          {31'd0, zero},        {31'd0, g.zero});
            chk("ovf",           {31'd0, ovf},         {31'd0, g.ovf});
            chk("pc_plus4_f",    pc_plus4_f,           g.pc4);
            chk("branch_target", branch_target,        g.bt);
            r_last = g;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset = 1; hold = 0; alu_op = 0; alu_a = 0; alu_b = 0;
        pc_f = 0; pc_plus4_d = 0; imm_ext = 0;

        // reset state
        step(1, 0, 3'd2, 32'h1234, 32'h1, 32'h100, 32'h200, 32'h3);
        // directed cases
        step(0, 0, 3'd2, 32'h7FFFFFFF, 32'h1, 32'h00400000, 32'h00400010, 32'hFFFFFFFE);
        step(0, 0, 3'd6, 32'd5, 32'd5, 32'hFFFFFFFC, 32'h0, 32'h1);
        step(0, 0, 3'd7, 32'hFFFFFFFF, 32'h1, 32'h10, 32'h20, 32'h0);
        step(0, 0, 3'd7, 32'h80000000, 32'h7FFFFFFF, 32'h14, 32'h24, 32'h8);
        step(0, 0, 3'd7, 32'h7FFFFFFF, 32'h80000000, 32'h18, 32'h28, 32'h0);
        step(0, 0, 3'd6, 32'h80000000, 32'h1, 32'h1C, 32'h2C, 32'h0);
        step(0, 0, 3'd5, 32'h1, 32'd31, 32'h20, 32'h30, 32'h0);
        step(0, 0, 3'd4, 32'h80000000, 32'd31, 32'h24, 32'h34, 32'h0);
        step(0, 0, 3'd4, 32'hF0F0F0F0, 32'h24, 32'h28, 32'h38, 32'h0);
        step(0, 0, 3'd0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h2C, 32'h3C, 32'h1);
        step(0, 0, 3'd1, 32'hFF00FF00, 32'h0F0F0F0F, 32'h30, 32'h40, 32'h2);
        step(0, 0, 3'd3, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h34, 32'h44, 32'h3);
        // hold freezes for two cycles while inputs change
        step(0, 1, 3'd2, 32'h1, 32'h2, 32'h500, 32'h600, 32'h7);
        step(0, 1, 3'd1, 32'h3, 32'h4, 32'h504, 32'h604, 32'h9);
        step(0, 0, 3'd2, 32'h1, 32'h2, 32'h500, 32'h600, 32'h7);
        // reset beats hold
        step(1, 1, 3'd2, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h900, 32'h900, 32'h9);
        // first result after reset deassertion
        step(0, 0, 3'd2, 32'h10, 32'h20, 32'h1000, 32'h2000, 32'hFFFFFFFF);
        // random mix
        for (int i = 0; i < 40; i++) begin
            step(0, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                 $urandom(), (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
                 $urandom(), $urandom(), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
